// File: rtl/jtmx5k_romarb_if.sv
// Bus bundle between the MX5000 ROM clients, the ROM read arbiter and the
// SDRAM controller read port.
interface jtmx5k_romarb_if #(
  parameter int AW = 18
);
  logic            downloading;
  logic [3:0]      slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [63:0]     slot_dout;
  logic            sdram_req;
  logic [21:0]     sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [15:0]     data_read;

  modport slave (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr
  );

  modport master (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtmx5k_romarb.sv
// Four-slot SDRAM read arbiter: one-word cache per slot, round-robin grant,
// a single outstanding SDRAM read at a time.
module jtmx5k_romarb #(
  parameter int          AW      = 18,
  parameter logic [21:0] OFFSET0 = 22'h000000,
  parameter logic [21:0] OFFSET1 = 22'h000000,
  parameter logic [21:0] OFFSET2 = 22'h000000,
  parameter logic [21:0] OFFSET3 = 22'h000000
) (
  input  logic             clk,
  input  logic             rst_n,
  jtmx5k_romarb_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          req_q, req_d;
  logic [21:0]   addr_q, addr_d;
  logic [AW-1:0] tag_next_q, tag_next_d;
  logic [3:0]    valid_q, valid_d;
  logic [AW-1:0] tag_q [4];
  logic [AW-1:0] tag_d [4];
  logic [15:0]   dout_q [4];
  logic [15:0]   dout_d [4];

  logic [AW-1:0] saddr [4];
  logic [3:0]    hit;
  logic [3:0]    pending;
  logic [1:0]    pick;

  function automatic logic [21:0] slot_offset(input logic [1:0] n);
    case (n)
      2'd0:    slot_offset = OFFSET0;
      2'd1:    slot_offset = OFFSET1;
      2'd2:    slot_offset = OFFSET2;
      default: slot_offset = OFFSET3;
    endcase
  endfunction

  // Hits are purely combinational so a cached word is served with no delay.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      saddr[n] = bus.slot_addr[n*AW +: AW];
      hit[n]   = bus.slot_cs[n] & valid_q[n] & (saddr[n] == tag_q[n]);
    end
    pending = bus.slot_cs & ~hit;
  end

  // Scan downwards so the slot closest after rr_q wins; rr_q itself is last.
  always_comb begin
    pick = rr_q;
    for (int k = 4; k >= 1; k--) begin
      if (pending[2'(rr_q + 2'(k))]) pick = 2'(rr_q + 2'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    tag_next_d = tag_next_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    dout_d     = dout_q;
    if (bus.downloading) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending) begin
            gnt_d      = pick;
            rr_d       = pick;
            addr_d     = slot_offset(pick) + 22'(saddr[pick]);
            tag_next_d = saddr[pick];
            req_d      = 1'b1;
            state_d    = ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            req_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The fill uses the captured tag, so an address change meanwhile misses.
          if (bus.data_rdy) begin
            dout_d[gnt_q]  = bus.data_read;
            tag_d[gnt_q]   = tag_next_q;
            valid_d[gnt_q] = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= 2'd3;
      gnt_q      <= 2'd0;
      req_q      <= 1'b0;
      addr_q     <= 22'd0;
      tag_next_q <= '0;
      valid_q    <= 4'd0;
      for (int n = 0; n < 4; n++) begin
        tag_q[n]  <= '0;
        dout_q[n] <= 16'd0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      tag_next_q <= tag_next_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) bus.slot_dout[n*16 +: 16] = dout_q[n];
  end

  assign bus.slot_ok    = hit;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;

endmodule
